// File: rtl/fifo_event_arbiter.sv
`default_nettype none
// fifo_event_arbiter: round-robin merge of four event-framed FIFOs into one word stream.
// Optional macro ARB_TIMEOUT_EN adds a mid-event abort after TIMEOUT_CYCLES stalled cycles.
module fifo_event_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  fifo_empty_i,
    input  logic [3:0]  fifo_valid_i,
    input  logic [91:0] fifo_data_i,
    output logic [3:0]  read_enable_o,
    input  logic        hold_in_i,
    output logic [22:0] data_out_o,
    output logic        dv_o,
    output logic [1:0]  src_ch_o,
    output logic        busy_o,
    output logic        timeout_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  rdy_q;
    logic [22:0] data_out_q, data_out_d;
    logic [1:0]  src_ch_q, src_ch_d;
    logic        dv_q, dv_d;
    logic [22:0] word;
    logic [2:0]  pick;
    logic        rd_block;

    // Returns {found, channel}; the last grant itself has the lowest priority.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] empty);
        logic [2:0] sel;
        logic [1:0] idx;
        sel = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (!empty[idx]) begin
                sel = {1'b1, idx};
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(last_grant_q, fifo_empty_i);

    always_comb begin
        case (grant_q)
            2'd0:    word = fifo_data_i[22:0];
            2'd1:    word = fifo_data_i[45:23];
            2'd2:    word = fifo_data_i[68:46];
            default: word = fifo_data_i[91:69];
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    discard_q, discard_d;
    logic          terr_q, terr_d;
    logic          capture;

    assign capture       = (state_q == S_WAIT) && fifo_valid_i[grant_q];
    // A channel whose read was abandoned stays unread until its stale word drains.
    assign rd_block      = discard_q[grant_q];
    assign timeout_err_o = terr_q;
`else
    assign rd_block      = 1'b0;
    assign timeout_err_o = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        data_out_d    = data_out_q;
        src_ch_d      = src_ch_q;
        dv_d          = 1'b0;
        read_enable_o = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        terr_d        = 1'b0;
        discard_d     = discard_q & ~fifo_valid_i;
`endif
        case (state_q)
            S_IDLE: begin
                if (rdy_q[1] && !hold_in_i && pick[2]) begin
                    grant_d = pick[1:0];
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!fifo_empty_i[grant_q] && !hold_in_i && !rd_block) begin
                    read_enable_o[grant_q] = 1'b1;
                    state_d                = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fifo_valid_i[grant_q]) begin
                    data_out_d = word;
                    src_ch_d   = grant_q;
                    dv_d       = 1'b1;
                    if (word[22]) begin
                        last_grant_d = grant_q;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef ARB_TIMEOUT_EN
        if (state_q == S_IDLE || capture) begin
            cnt_d = '0;
        end else if (cnt_q == C_TMO_LAST) begin
            cnt_d         = '0;
            read_enable_o = 4'b0000;
            data_out_d    = 23'h5FFFFF;
            src_ch_d      = grant_q;
            dv_d          = 1'b1;
            terr_d        = 1'b1;
            last_grant_d  = grant_q;
            state_d       = S_IDLE;
            if (state_q == S_WAIT) begin
                discard_d[grant_q] = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            rdy_q        <= 2'b00;
            data_out_q   <= 23'd0;
            src_ch_q     <= 2'd0;
            dv_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rdy_q        <= {rdy_q[0], 1'b1};
            data_out_q   <= data_out_d;
            src_ch_q     <= src_ch_d;
            dv_q         <= dv_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            discard_q <= 4'b0000;
            terr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            terr_q    <= terr_d;
        end
    end
`endif

    assign data_out_o = data_out_q;
    assign dv_o       = dv_q;
    assign src_ch_o   = src_ch_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/fifo_event_arbiter.md
FIFO_EVENT_ARBITER -- requirements
Module: fifo_event_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, max idle cycles mid-event before abort (used only with ARB_TIMEOUT_EN).
REQ-002 clock  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 fifo_empty  input  4  per-channel FIFO empty flag.
REQ-005 fifo_valid  input  4  per-channel FIFO read-data valid (one cycle after that channel's read enable).
REQ-006 fifo_data  input  92  four 23-bit FIFO outputs; channel k at bits [23k+22:23k]; bit 22 = end-event (ee), bit 21 = end-packet (ep).
REQ-007 read_enable  output  4  per-channel FIFO read strobe, one-hot or zero.
REQ-008 hold_in  input  1  downstream backpressure; 1 = issue no new reads.
REQ-009 data_out  output  23  merged event word.
REQ-010 dv  output  1  data_out valid strobe.
REQ-011 src_ch  output  2  channel that produced data_out.
REQ-012 busy  output  1  high while an event is being transferred.
REQ-013 timeout_err  output  1  one-cycle pulse on event abort.

Function
REQ-014 States: IDLE, REQ, WAIT; at most one read outstanding at any time.
REQ-015 IDLE: if hold_in=0 and any fifo_empty bit is 0, grant the first non-empty channel searching round-robin from last_grant+1 (mod 4), then enter REQ in the next cycle; otherwise stay in IDLE.
REQ-016 REQ: assert read_enable[grant] for exactly one cycle if fifo_empty[grant]=0 and hold_in=0, then enter WAIT; otherwise stay in REQ with read_enable=0.
REQ-017 WAIT: on fifo_valid[grant]=1, register fifo_data of grant into data_out, set src_ch=grant, and pulse dv in the following cycle; a fifo_valid bit on any non-granted channel is ignored.
REQ-018 WAIT exit: if the captured word has bit22=1, update last_grant to grant and enter IDLE; otherwise enter REQ.
REQ-019 Events are never interleaved: once granted, a channel keeps the grant until its ee word is forwarded or the event is aborted.
REQ-020 Latency: read_enable to dv is exactly 2 cycles; maximum throughput is one word per 2 cycles.
REQ-021 busy = 1 in REQ and WAIT; busy = 0 in IDLE.
REQ-022 hold_in asserted during WAIT does not drop the in-flight word; it is still forwarded.
REQ-023 Simultaneous requests: with last_grant=3 and all four channels non-empty, the order is 0,1,2,3,0.
REQ-024 Channel data bits 21:0 pass through unmodified.

Reset
REQ-025 On reset=0, immediately: state=IDLE, last_grant=3, read_enable=0, dv=0, data_out=0, src_ch=0, busy=0, timeout_err=0, timeout counter=0.
REQ-026 Reset asserted mid-event abandons the event, with no partial-event word output after reset is released.
REQ-027 Reset release is synchronised to clock; the first grant occurs no earlier than the 2nd rising edge after release.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN: when defined, a counter runs in REQ and WAIT, clears on each captured word, and on reaching TIMEOUT_CYCLES forces data_out=23'h5FFFFF (ee=1, ep=0), dv=1, timeout_err=1 for one cycle, then advances last_grant and enters IDLE; an outstanding fifo_valid that arrives later for that channel is discarded.
REQ-029 Without ARB_TIMEOUT_EN: no counter is present, timeout_err is tied to 0, and the arbiter waits indefinitely mid-event.

Verification
REQ-030 Ch1 holds a 3-word event (last word ee=1), all others empty -> 3 dv pulses, src_ch=1, each dv 2 cycles after its read_enable, then busy=0.
REQ-031 All channels each hold 2-word events, initial state after reset -> events output complete and non-interleaved in channel order 0,1,2,3.
REQ-032 hold_in=1 for 10 cycles starting mid-event on ch2 -> no read_enable during hold, in-flight word still forwarded, transfer resumes after hold_in falls.
REQ-033 Ch0 sends 1 word without ee, then goes empty for TIMEOUT_CYCLES, macro defined -> dv with data_out=23'h5FFFFF, timeout_err pulse, next grant goes to ch1; without macro -> stays busy, no output.
REQ-034 reset=0 pulsed during WAIT on ch3 -> all outputs 0 immediately, first grant after release goes to ch0.
